axis_rng_arbiter: RTL and testbench
===================================

AXIS_RNG_ARBITER -- requirements
Module: axis_rng_arbiter

Interface
REQ-001 Parameter PORTS, default 4, is the number of requester ports (2..8).
REQ-002 Parameter BURST_LEN, default 4, is the maximum number of words per grant (1..255).
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 gen_axis_tdata  input  32  random word from the generator.
REQ-006 gen_axis_tvalid  input  1  generator word valid.
REQ-007 gen_axis_tready  output  1  arbiter accepts the generator word.
REQ-008 gen_busy  input  1  generator seeding in progress.
REQ-009 gen_seed_val  output  32  seed presented to the generator.
REQ-010 gen_seed_start  output  1  one-cycle seed command to the generator.
REQ-011 req  input  PORTS  level request per port; a port wants words while its bit is high.
REQ-012 output_axis_tdata  output  PORTS*32  per-port data; port i occupies bits [32i+31:32i].
REQ-013 output_axis_tvalid  output  PORTS  per-port valid.
REQ-014 output_axis_tready  input  PORTS  per-port ready.
REQ-015 seed_val  input  32  host seed value.
REQ-016 seed_req  input  1  host reseed request, sampled as a level in IDLE.
REQ-017 seed_ack  output  1  one-cycle pulse when a reseed completes.
REQ-018 grant  output  PORTS  one-hot current grant, all zero when no port is granted.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM states SHALL be IDLE, XFER, SEED, SEED_WAIT and FLUSH.
REQ-021 In IDLE, a high seed_req SHALL take priority: latch seed_val into gen_seed_val and go to SEED.
- Otherwise, if any req bit is high, grant the first requesting port in round-robin order starting after the last granted port, and go to XFER.
- After reset, the search starts at port 0.
REQ-022 In XFER, data SHALL pass combinationally for the granted port g.
- output_axis_tdata[g] = gen_axis_tdata.
- output_axis_tvalid[g] = gen_axis_tvalid.
- gen_axis_tready = output_axis_tready[g].
- All other ports: tvalid 0, tdata 0.
REQ-023 The burst counter SHALL increment on each gen_axis_tvalid & gen_axis_tready handshake in XFER.
REQ-024 XFER SHALL return to IDLE on the handshake that makes the count equal BURST_LEN.
REQ-025 XFER SHALL also return to IDLE in any cycle where req[g] is low and no word is pending, meaning gen_axis_tvalid is low or output_axis_tready[g] is high.
- A word already presented (valid high, ready low) SHALL stay granted until it is accepted, so that AXI valid is never withdrawn.
REQ-026 On leaving XFER, grant SHALL clear and the last-granted pointer SHALL update to g.
REQ-027 A seed_req arriving during XFER SHALL wait until the burst ends; it is then serviced in IDLE ahead of any requester.
REQ-028 In SEED, gen_seed_start SHALL be 1 for exactly one cycle, and the FSM moves to SEED_WAIT.
REQ-029 SEED_WAIT SHALL last at least one cycle and SHALL exit when gen_busy is low.
- If gen_axis_tvalid is high on exit, go to FLUSH.
- Otherwise go to IDLE with seed_ack = 1 for that cycle.
REQ-030 FLUSH SHALL assert gen_axis_tready for one cycle to discard the stale pre-seed word, then return to IDLE with seed_ack pulsed.
- The discarded word SHALL NOT appear on any output port.
REQ-031 gen_axis_tready SHALL be 0 in IDLE, SEED and SEED_WAIT, and all output tvalid bits SHALL be 0 outside XFER.
REQ-032 A req bit that drops while its port is not granted SHALL have no effect.

Reset
REQ-033 While rst_n is low at a clock edge, the following SHALL be zero from the next cycle:
- state = IDLE, grant = 0, burst count = 0, last-granted pointer = PORTS-1.
- gen_seed_start = 0, gen_seed_val = 0, seed_ack = 0, busy = 0.
- All output_axis_tvalid = 0 and gen_axis_tready = 0.
REQ-034 Reset mid-XFER or mid-SEED_WAIT SHALL abandon the operation with no seed_ack, and no output valid SHALL remain high.

Verification
REQ-035 Ports 0 and 2 hold req high with tready always 1, BURST_LEN=4 -> grant alternates 0001 for 4 words, then 0100 for 4 words, then 0001 again; no word is duplicated or lost versus the generator sequence.
REQ-036 Port 1 tready low with a word presented while req[1] drops -> grant holds, tvalid[1] stays 1 until tready rises, and the FSM returns to IDLE the cycle after that handshake.
REQ-037 seed_req=1 with seed_val=5489 while port 3 is mid-burst -> the burst completes, then gen_seed_start pulses once with gen_seed_val=5489, seed_ack pulses after gen_busy falls, and the next word delivered equals the first MT19937 output for seed 5489 (0xD091BB5C).
REQ-038 Generator holds a stale valid word at reseed -> the FLUSH cycle shows gen_axis_tready=1 with every output tvalid 0, and the stale data never reaches any port.
REQ-039 rst_n low for one cycle during SEED_WAIT -> the next cycle has busy=0, grant=0, gen_seed_start=0, and seed_ack is never pulsed.
REQ-040 All req bits low for 100 cycles -> the FSM stays in IDLE, with gen_axis_tready=0 and busy=0 throughout.

Source files
------------

// File: rtl/axis_rng_arbiter.sv
// Round-robin arbiter that shares one 32-bit random-number stream among PORTS
// AXI-Stream consumers in bursts, and also sequences host reseed requests to the generator.
module axis_rng_arbiter #(
    parameter int PORTS     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           gen_axis_tdata,
    input  logic                  gen_axis_tvalid,
    output logic                  gen_axis_tready,
    input  logic                  gen_busy,
    output logic [31:0]           gen_seed_val,
    output logic                  gen_seed_start,
    input  logic [PORTS-1:0]      req,
    output logic [PORTS*32-1:0]   output_axis_tdata,
    output logic [PORTS-1:0]      output_axis_tvalid,
    input  logic [PORTS-1:0]      output_axis_tready,
    input  logic [31:0]           seed_val,
    input  logic                  seed_req,
    output logic                  seed_ack,
    output logic [PORTS-1:0]      grant,
    output logic                  busy
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        SEED,
        SEED_WAIT,
        FLUSH
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [IDX_W-1:0]   last_ptr, last_ptr_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [31:0]        seed_val_nxt;
    logic [IDX_W-1:0]   rr_idx;
    logic               gnt_req;
    logic               gnt_rdy;
    logic               xfer_hs;
    logic               burst_done;

    // First requesting port strictly after 'last', wrapping; the iteration runs
    // backwards so the nearest candidate is the one left in 'pick'.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [PORTS-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = last;
        for (int i = PORTS; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % PORTS);
            if (r[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign rr_idx     = rr_pick(req, last_ptr);
    assign gnt_req    = req[gnt_idx];
    assign gnt_rdy    = output_axis_tready[gnt_idx];
    assign xfer_hs    = gen_axis_tvalid & gnt_rdy;
    assign burst_done = ({1'b0, burst_cnt} + 9'd1) == 9'(BURST_LEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt_idx      <= '0;
            last_ptr     <= IDX_W'(PORTS - 1);
            burst_cnt    <= '0;
            gen_seed_val <= '0;
        end else begin
            state        <= state_nxt;
            gnt_idx      <= gnt_idx_nxt;
            last_ptr     <= last_ptr_nxt;
            burst_cnt    <= burst_cnt_nxt;
            gen_seed_val <= seed_val_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        gnt_idx_nxt     = gnt_idx;
        last_ptr_nxt    = last_ptr;
        burst_cnt_nxt   = burst_cnt;
        seed_val_nxt    = gen_seed_val;
        gen_axis_tready = 1'b0;
        gen_seed_start  = 1'b0;
        seed_ack        = 1'b0;
        grant           = '0;
        busy            = (state != IDLE);

        case (state)
            IDLE: begin
                if (seed_req) begin
                    seed_val_nxt = seed_val;
                    state_nxt    = SEED;
                end else if (|req) begin
                    gnt_idx_nxt   = rr_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = XFER;
                end
            end
            XFER: begin
                grant           = {{(PORTS-1){1'b0}}, 1'b1} << gnt_idx;
                gen_axis_tready = gnt_rdy;
                if (xfer_hs) burst_cnt_nxt = burst_cnt + 1'b1;
                // A presented but unaccepted word keeps the grant even after req drops.
                if ((xfer_hs && burst_done) ||
                    (!gnt_req && (!gen_axis_tvalid || gnt_rdy))) begin
                    state_nxt     = IDLE;
                    last_ptr_nxt  = gnt_idx;
                    burst_cnt_nxt = '0;
                end
            end
            SEED: begin
                gen_seed_start = 1'b1;
                state_nxt      = SEED_WAIT;
            end
            SEED_WAIT: begin
                if (!gen_busy) begin
                    if (gen_axis_tvalid) begin
                        state_nxt = FLUSH;
                    end else begin
                        seed_ack  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                // Drain the word produced under the old seed without routing it anywhere.
                gen_axis_tready = 1'b1;
                seed_ack        = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        output_axis_tdata  = '0;
        output_axis_tvalid = '0;
        if (state == XFER) begin
            for (int p = 0; p < PORTS; p++) begin
                if (gnt_idx == IDX_W'(p)) begin
                    output_axis_tdata[p*DATA_W +: DATA_W] = gen_axis_tdata;
                    output_axis_tvalid[p]                 = gen_axis_tvalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_rng_arbiter.sv
// Bench for axis_rng_arbiter: behavioural generator, data scoreboard,
// a per-cycle grant vector table and hand-written reseed/reset sequences.
module tb_axis_rng_arbiter;

    localparam int PORTS     = 4;
    localparam int BURST_LEN = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         gen_axis_tdata;
    logic                gen_axis_tvalid;
    logic                gen_axis_tready;
    logic                gen_busy;
    logic [31:0]         gen_seed_val;
    logic                gen_seed_start;
    logic [PORTS-1:0]    req;
    logic [PORTS*32-1:0] output_axis_tdata;
    logic [PORTS-1:0]    output_axis_tvalid;
    logic [PORTS-1:0]    output_axis_tready;
    logic [31:0]         seed_val;
    logic                seed_req;
    logic                seed_ack;
    logic [PORTS-1:0]    grant;
    logic                busy;

    always #5 clk = ~clk;

    axis_rng_arbiter #(.PORTS(PORTS), .BURST_LEN(BURST_LEN)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gen_axis_tdata     (gen_axis_tdata),
        .gen_axis_tvalid    (gen_axis_tvalid),
        .gen_axis_tready    (gen_axis_tready),
        .gen_busy           (gen_busy),
        .gen_seed_val       (gen_seed_val),
        .gen_seed_start     (gen_seed_start),
        .req                (req),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .seed_val           (seed_val),
        .seed_req           (seed_req),
        .seed_ack           (seed_ack),
        .grant              (grant),
        .busy               (busy)
    );

    typedef struct {
        logic [PORTS-1:0] req;
        logic [PORTS-1:0] exp_grant;
        logic             exp_busy;
        logic             exp_gready;
    } vec_t;

    vec_t        vecs[16];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] next_word;
    int          busy_left;
    bit          keep_stale;
    bit          gen_en;
    int          ack_cnt;
    int          start_cnt;
    int          out_cnt;
    logic [31:0] last_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample pre-edge handshakes, then advance the generator model.
    task automatic tick();
        logic        g_hs;
        logic        s_cmd;
        logic        busy_prev;
        logic [31:0] s_val;
        logic [31:0] exp_w;
        #1;
        g_hs  = gen_axis_tvalid & gen_axis_tready;
        s_cmd = gen_seed_start;
        s_val = gen_seed_val;
        if (seed_ack === 1'b1) ack_cnt++;
        if (s_cmd === 1'b1) start_cnt++;
        for (int p = 0; p < PORTS; p++) begin
            if (output_axis_tvalid[p] === 1'b1 && output_axis_tready[p] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_depth", sb_q.size(), 1);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("sb_data", output_axis_tdata[p*32 +: 32], exp_w);
                end
                last_out = output_axis_tdata[p*32 +: 32];
                out_cnt++;
            end
        end
        @(posedge clk);
        #1;
        busy_prev = gen_busy;
        if (g_hs === 1'b1) gen_axis_tvalid = 1'b0;
        if (s_cmd === 1'b1) begin
            if (gen_axis_tvalid) void'(sb_q.pop_back());
            if (!keep_stale) gen_axis_tvalid = 1'b0;
            next_word = (s_val == 32'd5489) ? 32'hD091BB5C : s_val;
            busy_left = 3;
            gen_busy  = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) gen_busy = 1'b0;
        end
        if (!gen_axis_tvalid && gen_en && !busy_prev && !gen_busy) begin
            gen_axis_tdata  = next_word;
            gen_axis_tvalid = 1'b1;
            sb_q.push_back(next_word);
            next_word = next_word * 32'd1664525 + 32'd1013904223;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int oc0;
        int flush_seen;
        int viol;

        rst_n = 1'b0; req = '0; output_axis_tready = '1;
        seed_req = 1'b0; seed_val = '0;
        gen_axis_tdata = '0; gen_axis_tvalid = 1'b0; gen_busy = 1'b0;
        gen_en = 1'b1; keep_stale = 1'b0; next_word = 32'h1000_0001; busy_left = 0;
        ack_cnt = 0; start_cnt = 0; out_cnt = 0; last_out = '0;

        for (int i = 0; i < 15; i++) vecs[i] = '{4'b0101, 4'b0000, 1'b0, 1'b0};
        for (int i = 1; i <= 4; i++)  vecs[i] = '{4'b0101, 4'b0001, 1'b1, 1'b1};
        for (int i = 6; i <= 9; i++)  vecs[i] = '{4'b0101, 4'b0100, 1'b1, 1'b1};
        for (int i = 11; i <= 14; i++) vecs[i] = '{4'b0101, 4'b0001, 1'b1, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0};

        // Reset state
        req = 4'b1111;
        tick(); tick();
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_gready", gen_axis_tready, 0);
        check("rst_tvalid", output_axis_tvalid, 0);
        check("rst_seed_start", gen_seed_start, 0);
        check("rst_seed_val", gen_seed_val, 0);
        check("rst_seed_ack", seed_ack, 0);
        rst_n = 1'b1;

        // Round-robin bursts between ports 0 and 2
        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req;
            #1;
            check($sformatf("rr_grant[%0d]", i), grant, vecs[i].exp_grant);
            check($sformatf("rr_busy[%0d]", i), busy, vecs[i].exp_busy);
            check($sformatf("rr_gready[%0d]", i), gen_axis_tready, vecs[i].exp_gready);
            check($sformatf("rr_tvalid[%0d]", i), output_axis_tvalid, vecs[i].exp_grant);
            tick();
        end

        // Port 1 drops req with a word stalled on tready
        req = 4'b0010;
        tick();
        req = 4'b0000; output_axis_tready = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hold_grant", grant, 4'b0010);
            check("hold_tvalid", output_axis_tvalid, 4'b0010);
            check("hold_gready", gen_axis_tready, 0);
            tick();
        end
        output_axis_tready = 4'b1111;
        #1;
        check("release_gready", gen_axis_tready, 1);
        tick();
        #1;
        check("release_busy", busy, 0);
        check("release_grant", grant, 0);

        // Reseed arriving while port 3 is mid-burst
        req = 4'b1000;
        tick();
        #1;
        check("p3_grant", grant, 4'b1000);
        tick();
        seed_req = 1'b1; seed_val = 32'd5489;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("p3_burst_continues", grant, 4'b1000);
            tick();
        end
        #1;
        check("seed_after_burst_busy", busy, 0);
        ack_cnt = 0; start_cnt = 0;
        tick();
        #1;
        check("seed_start", gen_seed_start, 1);
        check("seed_val_out", gen_seed_val, 32'd5489);
        seed_req = 1'b0;
        tick();
        n = 0;
        while (ack_cnt == 0 && n < 20) begin
            #1;
            if (seed_ack === 1'b1) check("ack_gen_busy", gen_busy, 0);
            check("seedwait_start", gen_seed_start, 0);
            tick();
            n++;
        end
        check("seed_ack_count", ack_cnt, 1);
        check("seed_start_count", start_cnt, 1);
        oc0 = out_cnt; n = 0;
        while (out_cnt == oc0 && n < 20) begin tick(); n++; end
        check("seeded_word_seen", out_cnt - oc0, 1);
        check("seeded_word", last_out, 32'hD091BB5C);
        req = 4'b0000;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); #1; n++; end
        check("p3_idle", busy, 0);

        // Stale generator word flushed at reseed
        keep_stale = 1'b1; ack_cnt = 0; flush_seen = 0;
        seed_req = 1'b1; seed_val = 32'h0000_1234;
        tick();
        seed_req = 1'b0;
        tick();
        n = 0;
        while (ack_cnt == 0 && n < 20) begin
            #1;
            if (gen_axis_tready === 1'b1) begin
                flush_seen++;
                check("flush_tvalid", output_axis_tvalid, 0);
                check("flush_grant", grant, 0);
                check("flush_ack", seed_ack, 1);
            end else begin
                check("seedwait_tvalid", output_axis_tvalid, 0);
            end
            tick();
            n++;
        end
        check("flush_seen", flush_seen, 1);
        check("flush_ack_count", ack_cnt, 1);
        keep_stale = 1'b0;
        req = 4'b0001;
        oc0 = out_cnt; n = 0;
        while (out_cnt == oc0 && n < 20) begin tick(); n++; end
        check("post_flush_word", last_out, 32'h0000_1234);
        req = 4'b0000;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); #1; n++; end
        check("flush_idle", busy, 0);

        // Reset during SEED_WAIT
        ack_cnt = 0;
        seed_req = 1'b1; seed_val = 32'h0000_ABCD;
        tick();
        seed_req = 1'b0;
        tick();
        #1;
        check("sw_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("sw_rst_busy", busy, 0);
        check("sw_rst_grant", grant, 0);
        check("sw_rst_start", gen_seed_start, 0);
        check("sw_rst_seed_val", gen_seed_val, 0);
        check("sw_rst_tvalid", output_axis_tvalid, 0);
        repeat (8) tick();
        check("sw_rst_no_ack", ack_cnt, 0);

        // Reset during XFER
        req = 4'b0001;
        tick();
        #1;
        check("xfer_tvalid", output_axis_tvalid, 4'b0001);
        rst_n = 1'b0; req = 4'b0000;
        tick();
        rst_n = 1'b1;
        #1;
        check("xfer_rst_tvalid", output_axis_tvalid, 0);
        check("xfer_rst_grant", grant, 0);
        check("xfer_rst_busy", busy, 0);

        // Idle for 100 cycles with no requests
        viol = 0;
        repeat (100) begin
            #1;
            if (gen_axis_tready !== 1'b0 || busy !== 1'b0 || output_axis_tvalid !== '0) viol++;
            tick();
        end
        check("idle_100", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
